// File: rtl/rob_cir_q_pkg.sv
// rob_cir_q_pkg: shared defaults, index/pointer types and live-window test
package rob_cir_q_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int N_UPD_DEF = 2;
  localparam int IDX_W_DEF = $clog2(DEPTH_DEF);
  typedef logic [IDX_W_DEF-1:0] idx_t;
  typedef logic [IDX_W_DEF:0] ptr_t;
  function automatic logic in_window(ptr_t head, ptr_t tail, idx_t i);
    idx_t off;
    ptr_t cnt;
    off = i - head[IDX_W_DEF-1:0];
    cnt = tail - head;
    return {1'b0, off} < cnt;
  endfunction
endpackage

// File: rtl/rob_cir_q_ptr.sv
// rob_cir_q_ptr: wrap-bit pointer register with increment enable and synchronous clear
module rob_cir_q_ptr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr ? '0 : inc ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/rob_cir_q.sv
// rob_cir_q: reorder-buffer circular queue, in-order issue/retire with out-of-order completion
module rob_cir_q
  import rob_cir_q_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int N_UPD = N_UPD_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue,
  input  logic [DATA_W-1:0]       datain_issue,
  output logic                    issue_ready,
  output logic [IDX_W-1:0]        issue_idx,
  input  logic [N_UPD-1:0]        update,
  input  logic [N_UPD*IDX_W-1:0]  update_index,
  input  logic [N_UPD*DATA_W-1:0] datain_update,
  output logic                    commit_valid,
  input  logic                    commit,
  output logic [DATA_W-1:0]       dataout,
  output logic [IDX_W-1:0]        commit_idx,
  input  logic                    flush,
  output logic                    cir_q_full,
  output logic                    cir_q_empty,
  output logic [IDX_W:0]          count,
  output logic [IDX_W-1:0]        issue_ptr_dbg,
  output logic [IDX_W-1:0]        commit_ptr_dbg
);
  logic [IDX_W:0] ip, cp;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] done_q, done_d;
  logic [N_UPD-1:0] upd_ok;
  logic issue_fire, retire_fire;
  assign count = ip - cp;
  assign cir_q_empty = ip == cp;
  assign cir_q_full = (ip[IDX_W-1:0] == cp[IDX_W-1:0]) && (ip[IDX_W] != cp[IDX_W]);
  assign issue_ready = !cir_q_full;
  assign issue_idx = ip[IDX_W-1:0];
  assign commit_idx = cp[IDX_W-1:0];
  assign issue_ptr_dbg = ip[IDX_W-1:0];
  assign commit_ptr_dbg = cp[IDX_W-1:0];
  assign commit_valid = !cir_q_empty && done_q[cp[IDX_W-1:0]];
  assign dataout = mem_q[cp[IDX_W-1:0]];
  assign issue_fire = issue && !cir_q_full && !flush;
  assign retire_fire = commit_valid && commit && !flush;
  always_comb begin
    upd_ok = '0;
    for (int p = 0; p < N_UPD; p++)
      upd_ok[p] = update[p] && !flush &&
                  ({1'b0, IDX_W'(update_index[p*IDX_W +: IDX_W] - cp[IDX_W-1:0])} < count);
  end
  always_comb begin
    mem_d = mem_q;
    done_d = done_q;
    for (int p = 0; p < N_UPD; p++)
      if (upd_ok[p]) begin
        mem_d[update_index[p*IDX_W +: IDX_W]] = datain_update[p*DATA_W +: DATA_W];
        done_d[update_index[p*IDX_W +: IDX_W]] = 1'b1;
      end
    if (issue_fire) begin
      mem_d[ip[IDX_W-1:0]] = datain_issue;
      done_d[ip[IDX_W-1:0]] = 1'b0;
    end
    if (flush) done_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) done_q <= '0;
    else done_q <= done_d;
  always_ff @(posedge clk) mem_q <= mem_d;
  rob_cir_q_ptr #(.W(IDX_W+1)) u_issue_ptr (.clk(clk), .rst_n(rst_n), .clr(flush), .inc(issue_fire), .ptr(ip));
  rob_cir_q_ptr #(.W(IDX_W+1)) u_commit_ptr (.clk(clk), .rst_n(rst_n), .clr(flush), .inc(retire_fire), .ptr(cp));
endmodule

// File: tb/tb_rob_cir_q.sv
// tb_rob_cir_q: directed self-checking bench for rob_cir_q
module tb_rob_cir_q;
  logic clk, rst_n, issue, issue_ready, commit_valid, commit, flush, cir_q_full, cir_q_empty;
  logic [31:0] datain_issue, dataout;
  logic [4:0] issue_idx, commit_idx, issue_ptr_dbg, commit_ptr_dbg;
  logic [1:0] update;
  logic [9:0] update_index;
  logic [63:0] datain_update;
  logic [5:0] count;
  int checks = 0;
  int errors = 0;
  rob_cir_q #(.DATA_W(32), .DEPTH(32), .N_UPD(2)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .datain_issue(datain_issue),
    .issue_ready(issue_ready), .issue_idx(issue_idx), .update(update),
    .update_index(update_index), .datain_update(datain_update),
    .commit_valid(commit_valid), .commit(commit), .dataout(dataout),
    .commit_idx(commit_idx), .flush(flush), .cir_q_full(cir_q_full),
    .cir_q_empty(cir_q_empty), .count(count), .issue_ptr_dbg(issue_ptr_dbg),
    .commit_ptr_dbg(commit_ptr_dbg)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
    issue = 0; commit = 0; flush = 0; update = 0;
  endtask
  task automatic set_upd(input int p, input logic [4:0] idx, input logic [31:0] d);
    update[p] = 1;
    update_index[p*5 +: 5] = idx;
    datain_update[p*32 +: 32] = d;
  endtask
  task automatic do_flush();
    flush = 1;
    step();
  endtask
  task automatic test_reset();
    checks++; if (cir_q_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", cir_q_empty); end
    checks++; if (cir_q_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", cir_q_full); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", issue_ready); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %0b exp 0", commit_valid); end
    checks++; if (issue_ptr_dbg !== 5'd0 || commit_ptr_dbg !== 5'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d exp 0/0", issue_ptr_dbg, commit_ptr_dbg); end
  endtask
  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      issue = 1; datain_issue = i;
      step();
    end
    checks++; if (cir_q_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", cir_q_full); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL fill_count got %0d exp 32", count); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b exp 0", issue_ready); end
    issue = 1; datain_issue = 32'hdead;
    step();
    checks++; if (issue_ptr_dbg !== 5'd0 || commit_ptr_dbg !== 5'd0) begin errors++; $display("FAIL fill_33_ptrs got %0d/%0d exp 0/0", issue_ptr_dbg, commit_ptr_dbg); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL fill_33_count got %0d exp 32", count); end
    do_flush();
  endtask
  task automatic test_ooo();
    for (int i = 0; i < 4; i++) begin
      issue = 1; datain_issue = 32'h10 + i;
      step();
    end
    set_upd(0, 5'd2, 32'h22);
    step();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_cv_idx2 got %0b exp 0", commit_valid); end
    set_upd(0, 5'd0, 32'h20);
    step();
    checks++; if (commit_valid !== 1'b1 || dataout !== 32'h20) begin errors++; $display("FAIL ooo_head got cv=%0b data=%h exp cv=1 data=20", commit_valid, dataout); end
    commit = 1;
    step();
    checks++; if (commit_valid !== 1'b0 || commit_idx !== 5'd1 || count !== 6'd3) begin errors++; $display("FAIL ooo_after_retire got cv=%0b idx=%0d cnt=%0d exp 0/1/3", commit_valid, commit_idx, count); end
  endtask
  task automatic test_same_idx();
    set_upd(0, 5'd3, 32'hAAAA);
    set_upd(1, 5'd3, 32'hBBBB);
    step();
    set_upd(0, 5'd20, 32'h2020);
    step();
    checks++; if (count !== 6'd3 || commit_valid !== 1'b0) begin errors++; $display("FAIL dead_upd got cnt=%0d cv=%0b exp 3/0", count, commit_valid); end
    set_upd(1, 5'd1, 32'h21);
    step();
    checks++; if (commit_valid !== 1'b1 || dataout !== 32'h21) begin errors++; $display("FAIL head1 got cv=%0b data=%h exp 1/21", commit_valid, dataout); end
    commit = 1;
    step();
    checks++; if (commit_valid !== 1'b1 || dataout !== 32'h22) begin errors++; $display("FAIL head2 got cv=%0b data=%h exp 1/22", commit_valid, dataout); end
    commit = 1;
    step();
    checks++; if (commit_valid !== 1'b1 || dataout !== 32'hBBBB) begin errors++; $display("FAIL same_idx_win got cv=%0b data=%h exp 1/bbbb", commit_valid, dataout); end
    commit = 1;
    step();
    checks++; if (cir_q_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b exp 1", cir_q_empty); end
    issue = 1; datain_issue = 32'h44;
    set_upd(0, 5'd4, 32'h4444);
    step();
    checks++; if (commit_valid !== 1'b0 || dataout !== 32'h44 || count !== 6'd1) begin errors++; $display("FAIL tail_upd got cv=%0b data=%h cnt=%0d exp 0/44/1", commit_valid, dataout, count); end
    do_flush();
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 32; i++) begin
      issue = 1; datain_issue = i;
      step();
    end
    for (int k = 0; k < 16; k++) begin
      set_upd(0, 5'(2*k), 32'h100 + 2*k);
      set_upd(1, 5'(2*k+1), 32'h101 + 2*k);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      checks++; if (commit_valid !== 1'b1 || dataout !== 32'h100 + k) begin errors++; $display("FAIL wrap_retire%0d got cv=%0b data=%h exp 1/%h", k, commit_valid, dataout, 32'h100 + k); end
      commit = 1;
      step();
    end
    for (int i = 0; i < 6; i++) begin
      issue = 1; datain_issue = 32'h200 + i;
      step();
    end
    checks++; if (cir_q_full !== 1'b1 || issue_ptr_dbg !== 5'd6 || commit_ptr_dbg !== 5'd6) begin errors++; $display("FAIL wrap_full got full=%0b ip=%0d cp=%0d exp 1/6/6", cir_q_full, issue_ptr_dbg, commit_ptr_dbg); end
    set_upd(0, 5'd2, 32'h333);
    step();
    for (int k = 6; k < 32; k++) begin
      checks++; if (commit_valid !== 1'b1 || dataout !== 32'h100 + k) begin errors++; $display("FAIL wrap_drain%0d got cv=%0b data=%h exp 1/%h", k, commit_valid, dataout, 32'h100 + k); end
      commit = 1;
      step();
    end
    checks++; if (commit_valid !== 1'b0 || commit_idx !== 5'd0 || count !== 6'd6) begin errors++; $display("FAIL wrap_head0 got cv=%0b idx=%0d cnt=%0d exp 0/0/6", commit_valid, commit_idx, count); end
    set_upd(0, 5'd0, 32'h300);
    set_upd(1, 5'd1, 32'h301);
    step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (commit_valid !== 1'b1 || dataout !== 32'h300 + k) begin errors++; $display("FAIL wrap_new%0d got cv=%0b data=%h exp 1/%h", k, commit_valid, dataout, 32'h300 + k); end
      commit = 1;
      step();
    end
    checks++; if (commit_valid !== 1'b1 || dataout !== 32'h333) begin errors++; $display("FAIL wrap_upd2 got cv=%0b data=%h exp 1/333", commit_valid, dataout); end
    do_flush();
  endtask
  task automatic test_flush();
    for (int i = 0; i < 10; i++) begin
      issue = 1; datain_issue = 32'h50 + i;
      step();
    end
    set_upd(0, 5'd0, 32'h500);
    step();
    issue = 1; commit = 1; datain_issue = 32'h5a;
    step();
    checks++; if (count !== 6'd10 || commit_idx !== 5'd1 || issue_idx !== 5'd11) begin errors++; $display("FAIL both_fire got cnt=%0d cidx=%0d iidx=%0d exp 10/1/11", count, commit_idx, issue_idx); end
    set_upd(0, 5'd1, 32'h501);
    step();
    flush = 1; issue = 1; commit = 1;
    step();
    checks++; if (cir_q_empty !== 1'b1 || count !== 6'd0 || commit_valid !== 1'b0) begin errors++; $display("FAIL flush got empty=%0b cnt=%0d cv=%0b exp 1/0/0", cir_q_empty, count, commit_valid); end
    checks++; if (issue_ptr_dbg !== 5'd0 || commit_ptr_dbg !== 5'd0) begin errors++; $display("FAIL flush_ptrs got %0d/%0d exp 0/0", issue_ptr_dbg, commit_ptr_dbg); end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      issue = 1; datain_issue = 32'h60 + i;
      step();
    end
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count); end
    #2 rst_n = 0;
    #1;
    checks++; if (cir_q_empty !== 1'b1 || count !== 6'd0 || issue_ptr_dbg !== 5'd0) begin errors++; $display("FAIL mid_reset got empty=%0b cnt=%0d ip=%0d exp 1/0/0", cir_q_empty, count, issue_ptr_dbg); end
    #1 rst_n = 1;
  endtask
  initial begin
    rst_n = 0; issue = 0; commit = 0; flush = 0; update = 0;
    datain_issue = 0; update_index = 0; datain_update = 0;
    #12;
    test_reset();
    rst_n = 1;
    step();
    test_fill();
    test_ooo();
    test_same_idx();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
